// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared constants and types for the PWM generator.
//   ANCHO_PWM    : default counter / duty width (period = 2^ANCHO_PWM clocks)
//   PASO_RAMPA   : default soft-start step per period (used with PWM_RAMPA_EN)
//   estado_pwm_t : run state of the generator
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int ANCHO_PWM  = 10;
    localparam int PASO_RAMPA = 32;

    typedef enum logic {
        INACTIVO = 1'b0,
        ACTIVO   = 1'b1
    } estado_pwm_t;

endpackage

// File: rtl/rampa_duty.sv
// -----------------------------------------------------------------------------
// rampa_duty
// Combinational next-shadow computation for the soft-start ramp. The applied
// duty moves toward the commanded duty by at most PASO per call; when the
// remaining distance is within PASO it lands exactly on the command.
// Works in both directions. All differences are taken in ANCHO+1 bits so
// nothing wraps.
// Ports:
//   duty_actual : current shadow duty
//   cuenta_max  : commanded duty
//   duty_sig    : duty to load at the next period boundary
// -----------------------------------------------------------------------------
module rampa_duty
    import pwm_pkg::*;
#(
    parameter int ANCHO = ANCHO_PWM,
    parameter int PASO  = PASO_RAMPA
) (
    input  logic [ANCHO-1:0] duty_actual,
    input  logic [ANCHO-1:0] cuenta_max,
    output logic [ANCHO-1:0] duty_sig
);

    // A step larger than the full range behaves like a direct load; clamp it
    // so it fits the ANCHO+1 bit arithmetic.
    localparam int             PASO_SAT = (PASO > (1 << ANCHO)) ? (1 << ANCHO) : PASO;
    localparam logic [ANCHO:0] PASO_W   = PASO_SAT[ANCHO:0];

    logic [ANCHO:0] actual_w;
    logic [ANCHO:0] objetivo_w;
    logic [ANCHO:0] dif;

    always_comb begin
        actual_w   = {1'b0, duty_actual};
        objetivo_w = {1'b0, cuenta_max};
        dif        = '0;
        duty_sig   = cuenta_max;
        if (objetivo_w > actual_w) begin
            dif = objetivo_w - actual_w;
            // dif > PASO guarantees actual+PASO < cuenta_max, so it fits ANCHO bits
            if (dif > PASO_W) begin
                duty_sig = ANCHO'(actual_w + PASO_W);
            end
        end else begin
            dif = actual_w - objetivo_w;
            // dif > PASO guarantees actual-PASO > cuenta_max, so no underflow
            if (dif > PASO_W) begin
                duty_sig = ANCHO'(actual_w - PASO_W);
            end
        end
    end

endmodule

// File: rtl/generador_pwm.sv
// -----------------------------------------------------------------------------
// generador_pwm
// Registered PWM generator. A free-running period counter is compared against
// a shadow copy of the commanded duty; the shadow only updates at the period
// boundary (counter = 2^ANCHO-1), so setpoint changes never cut a pulse short.
//
// Optional build macro: PWM_RAMPA_EN
//   defined   : shadow ramps toward cuenta_max by PASO per period and is held
//               at 0 while idle, so every enable soft-starts.
//   undefined : shadow loads cuenta_max directly at each boundary and tracks
//               it every cycle while idle.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   habilitar   : run enable; low forces output off and counter to 0
//   cuenta_max  : commanded duty (counts out of 2^ANCHO)
//   pwm_out     : gate drive, registered
//   fin_periodo : one-cycle pulse, last cycle of each period, registered
//   duty_actual : duty currently applied (shadow register)
//   estado      : current FSM state, for observation
//
// Output timing: pwm_out and fin_periodo are registered from the counter
// value, so they show the counter's cycle k one clock later. Enable sampled at
// edge N moves the FSM to ACTIVO with counter 0; the first high pulse appears
// after edge N+1.
// -----------------------------------------------------------------------------
module generador_pwm
    import pwm_pkg::*;
#(
    parameter int ANCHO = ANCHO_PWM,
    parameter int PASO  = PASO_RAMPA
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             habilitar,
    input  logic [ANCHO-1:0] cuenta_max,
    output logic             pwm_out,
    output logic             fin_periodo,
    output logic [ANCHO-1:0] duty_actual,
    output estado_pwm_t      estado
);

    localparam logic [ANCHO-1:0] CUENTA_FIN = '1;

    if (PASO < 1) begin : g_paso_invalido
        $error("generador_pwm: PASO must be at least 1");
    end

    estado_pwm_t      estado_sig;
    logic [ANCHO-1:0] contador;
    logic [ANCHO-1:0] contador_sig;
    logic [ANCHO-1:0] duty_sig;
    logic             pwm_sig;
    logic             fin_sig;
    logic [ANCHO-1:0] duty_frontera;

`ifdef PWM_RAMPA_EN
    rampa_duty #(
        .ANCHO (ANCHO),
        .PASO  (PASO)
    ) u_rampa (
        .duty_actual (duty_actual),
        .cuenta_max  (cuenta_max),
        .duty_sig    (duty_frontera)
    );
`else
    assign duty_frontera = cuenta_max;
`endif

    // Next state, counter, shadow and registered outputs.
    always_comb begin
        estado_sig   = estado;
        contador_sig = '0;
        duty_sig     = duty_actual;
        pwm_sig      = 1'b0;
        fin_sig      = 1'b0;
        case (estado)
            INACTIVO: begin
                if (habilitar) begin
                    estado_sig = ACTIVO;
                end
`ifdef PWM_RAMPA_EN
                duty_sig = '0;
`else
                duty_sig = cuenta_max;
`endif
            end
            ACTIVO: begin
                if (!habilitar) begin
                    // Abort immediately: counter and output clear next cycle.
                    estado_sig = INACTIVO;
                end else begin
                    contador_sig = contador + ANCHO'(1);
                    pwm_sig      = (contador < duty_actual);
                    fin_sig      = (contador == CUENTA_FIN);
                    if (contador == CUENTA_FIN) begin
                        duty_sig = duty_frontera;
                    end
                end
            end
            default: begin
                estado_sig = INACTIVO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= INACTIVO;
            contador    <= '0;
            duty_actual <= '0;
            pwm_out     <= 1'b0;
            fin_periodo <= 1'b0;
        end else begin
            estado      <= estado_sig;
            contador    <= contador_sig;
            duty_actual <= duty_sig;
            pwm_out     <= pwm_sig;
            fin_periodo <= fin_sig;
        end
    end

endmodule

// File: tb/tb_generador_pwm.sv
// -----------------------------------------------------------------------------
// tb_generador_pwm
// Directed self-checking bench for generador_pwm (ANCHO=10, PASO=32).
// Outputs are sampled 1 time unit after each rising edge; inputs are driven
// at the same point. Expected values are hand-computed from the behaviour
// of the generator: period 1024 clocks, duty d gives d high clocks first.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_generador_pwm;
    import pwm_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic        habilitar;
    logic [9:0]  cuenta_max;
    logic        pwm_out;
    logic        fin_periodo;
    logic [9:0]  duty_actual;
    estado_pwm_t estado;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generador_pwm #(
        .ANCHO (10),
        .PASO  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .habilitar   (habilitar),
        .cuenta_max  (cuenta_max),
        .pwm_out     (pwm_out),
        .fin_periodo (fin_periodo),
        .duty_actual (duty_actual),
        .estado      (estado)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the cycle showing fin_periodo (bounded).
    task automatic wait_fin(input string tag);
        for (int n = 0; n < 2100; n++) begin
            tick();
            if (fin_periodo) break;
        end
        check_val({tag, "_wait_fin"}, 32'(fin_periodo), 32'd1);
    endtask

    // Observe one full period starting right after a fin cycle. Optionally
    // change cuenta_max at sample index chg_at.
    task automatic check_period(input string tag, input logic [10:0] exp_highs,
                                input int chg_at, input logic [9:0] chg_val);
        int highs;
        int fins;
        int forma_ok;
        int vio_bajo;
        int fin_ultimo;
        highs      = 0;
        fins       = 0;
        forma_ok   = 1;
        vio_bajo   = 0;
        fin_ultimo = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i == chg_at) cuenta_max = chg_val;
            tick();
            if (pwm_out) begin
                highs++;
                if (vio_bajo != 0) forma_ok = 0;
            end else begin
                vio_bajo = 1;
            end
            if (fin_periodo) fins++;
            if (i == 1023) fin_ultimo = int'(fin_periodo);
        end
        check_val({tag, "_highs"}, 32'(highs), 32'(exp_highs));
        check_val({tag, "_shape"}, 32'(forma_ok), 32'd1);
        check_val({tag, "_fin_count"}, 32'(fins), 32'd1);
        check_val({tag, "_fin_last"}, 32'(fin_ultimo), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        habilitar  = 1'b0;
        cuenta_max = 10'd0;
        repeat (3) tick();
        check_val("rst_pwm", 32'(pwm_out), 32'd0);
        check_val("rst_fin", 32'(fin_periodo), 32'd0);
        check_val("rst_duty", 32'(duty_actual), 32'd0);
        check_val("rst_estado", 32'(estado), 32'(INACTIVO));

`ifndef PWM_RAMPA_EN
        // Idle shadow tracks the command every cycle.
        reset      = 1'b0;
        cuenta_max = 10'd512;
        tick();
        check_val("idle_track", 32'(duty_actual), 32'd512);

        // Enable latency: two clocks to the first high.
        habilitar = 1'b1;
        tick();
        check_val("lat_pwm_1", 32'(pwm_out), 32'd0);
        check_val("lat_estado", 32'(estado), 32'(ACTIVO));
        tick();
        check_val("lat_pwm_2", 32'(pwm_out), 32'd1);
        wait_fin("d512");
        check_period("d512", 11'd512, -1, 10'd0);

        // Edge duties through the expected queue.
        exp_q.push_back(11'd0);
        exp_q.push_back(11'd992);
        exp_q.push_back(11'd1023);
        while (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            cuenta_max = e[9:0];
            wait_fin("edge");
            check_val("edge_duty", 32'(duty_actual), 32'(e));
            check_period("edge", e, -1, 10'd0);
        end

        // Mid-period change 256 -> 768 does not affect the running period.
        cuenta_max = 10'd256;
        wait_fin("mid");
        check_period("mid_cur", 11'd256, 100, 10'd768);
        check_period("mid_next", 11'd768, -1, 10'd0);

        // Drop enable at counter ~50 with duty 800.
        cuenta_max = 10'd800;
        wait_fin("drop");
        repeat (50) tick();
        check_val("drop_pre_pwm", 32'(pwm_out), 32'd1);
        habilitar = 1'b0;
        tick();
        check_val("drop_pwm", 32'(pwm_out), 32'd0);
        check_val("drop_fin", 32'(fin_periodo), 32'd0);
        check_val("drop_estado", 32'(estado), 32'(INACTIVO));
        cuenta_max = 10'd300;
        tick();
        check_val("drop_track", 32'(duty_actual), 32'd300);
        habilitar = 1'b1;
        tick();
        check_val("reen_pwm_0", 32'(pwm_out), 32'd0);
        begin
            int n;
            int h;
            n = 0;
            h = 0;
            do begin
                tick();
                n++;
                if (pwm_out) h++;
            end while (!fin_periodo && n < 2100);
            check_val("reen_len", 32'(n), 32'd1024);
            check_val("reen_highs", 32'(h), 32'd300);
        end

        // Reset mid-period with duty 480, enable held high.
        cuenta_max = 10'd480;
        wait_fin("rst480");
        repeat (100) tick();
        check_val("rst480_pre", 32'(pwm_out), 32'd1);
        reset = 1'b1;
        tick();
        check_val("rst480_pwm", 32'(pwm_out), 32'd0);
        check_val("rst480_duty", 32'(duty_actual), 32'd0);
        check_val("rst480_fin", 32'(fin_periodo), 32'd0);
        begin
            int h;
            int f;
            int d;
            h = 0;
            f = 0;
            d = 0;
            for (int i = 0; i < 1100; i++) begin
                tick();
                if (pwm_out) h++;
                if (fin_periodo) f++;
                if (duty_actual != 10'd0) d++;
            end
            check_val("rst_hold_pwm", 32'(h), 32'd0);
            check_val("rst_hold_fin", 32'(f), 32'd0);
            check_val("rst_hold_duty", 32'(d), 32'd0);
        end
        reset = 1'b0;
        tick();
        check_val("post_rst_duty", 32'(duty_actual), 32'd480);
        check_val("post_rst_estado", 32'(estado), 32'(ACTIVO));
`else
        // Soft-start ramp: idle shadow held at 0.
        reset      = 1'b0;
        cuenta_max = 10'd100;
        tick();
        check_val("ramp_idle", 32'(duty_actual), 32'd0);
        habilitar = 1'b1;
        exp_q = '{11'd32, 11'd64, 11'd96, 11'd100};
        while (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            wait_fin("ramp_up");
            check_val("ramp_up", 32'(duty_actual), 32'(e));
        end
        cuenta_max = 10'd0;
        exp_q = '{11'd68, 11'd36, 11'd4, 11'd0};
        while (exp_q.size() > 0) begin
            logic [10:0] e;
            e = exp_q.pop_front();
            wait_fin("ramp_dn");
            check_val("ramp_dn", 32'(duty_actual), 32'(e));
        end
        check_period("ramp_zero", 11'd0, -1, 10'd0);
        habilitar = 1'b0;
        cuenta_max = 10'd500;
        repeat (2) tick();
        check_val("ramp_off", 32'(duty_actual), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/generador_pwm.md
# generador_pwm

Registered PWM generator that consumes `cuenta_max`, the 10-bit duty threshold produced by the current-setpoint decoder, and drives the power-stage gate signal. A free-running period counter is compared against a shadow copy of the duty value. The shadow updates only at period boundaries, so setpoint changes never produce runt pulses. An optional soft-start ramp limits how fast the applied duty approaches the commanded value.

## Interface
- `ANCHO`, 10: counter and duty width; period = 2^ANCHO clocks.
- `PASO`, 32: ramp step applied per period, used only with `PWM_RAMPA_EN`; must be ≥1.
- `clk`  input  1: system clock, rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `habilitar`  input  1: run enable; low forces output off and holds counter at 0.
- `cuenta_max`  input  ANCHO: commanded duty, in counts out of 2^ANCHO; any value 0..2^ANCHO-1 accepted.
- `pwm_out`  output  1: gate drive, registered.
- `fin_periodo`  output  1: one-cycle pulse in the last cycle of each period.
- `duty_actual`  output  ANCHO: duty value currently applied (shadow register).

## Operation
- Two states:
  - `INACTIVO`: entered on reset or when `habilitar`=0.
  - `ACTIVO`: entered when `habilitar`=1.
- `INACTIVO` behaviour:
  - Counter = 0, `pwm_out` = 0, `fin_periodo` = 0.
  - Without ramp, the shadow tracks `cuenta_max` every cycle.
  - With ramp, the shadow is forced to 0.
- `INACTIVO` → `ACTIVO` when `habilitar`=1. The counter starts at 0 in the following cycle.
- `ACTIVO`:
  - Counter increments by 1 each clock and wraps 2^ANCHO-1 → 0.
  - While the counter holds k, `pwm_out` = (k < duty_actual). Duty 0 gives a constant low; duty 1023 gives 1023 high clocks out of 1024.
- Period boundary: the cycle in which the counter holds 2^ANCHO-1.
  - `fin_periodo` = 1.
  - The shadow loads its next value, which takes effect from counter = 0.
- `ACTIVO` → `INACTIVO` when `habilitar`=0, at any counter value. In the next cycle `pwm_out` = 0 and the counter = 0; there is no completion of the period.
- `cuenta_max` is sampled only at the boundary, or every cycle while `INACTIVO` without ramp. Changes mid-period do not affect the current period.
- Unsigned arithmetic only. Ramp step computations use ANCHO+1 bits, so they never wrap.

## Timing
- Reset values: counter 0, `duty_actual` 0, `pwm_out` 0, `fin_periodo` 0, state `INACTIVO`. Reset overrides `habilitar`.
- Reset or `habilitar` falling mid-period: `pwm_out` is low in the next cycle, with no partial pulse completion.
- Latency from `habilitar` rising to the first `pwm_out` high: 2 clocks, when duty > 0.
- Latency from a `cuenta_max` change (while `ACTIVO`) to its effect on `pwm_out`: the start of the next period, i.e. at most 2^ANCHO clocks.
- `pwm_out` and `fin_periodo` are taken directly from flops, with no combinational path from inputs.

## Configuration
- Macro: `PWM_RAMPA_EN`.
- Defined: at each boundary the shadow moves toward `cuenta_max` by `PASO`.
  - If |cuenta_max − duty_actual| ≤ `PASO`, it loads `cuenta_max` exactly.
  - The ramp applies in both directions, rising and falling.
  - The shadow is 0 after reset or while `INACTIVO`, so every enable soft-starts.
- Undefined: at each boundary the shadow loads `cuenta_max` directly. There is no ramp logic and `PASO` is unused.

## Structure
- Package `pwm_pkg`:
  - `ANCHO_PWM` = 10 and `PASO_RAMPA` = 32 default constants.
  - Enum `estado_pwm_t` {`INACTIVO`, `ACTIVO`}.
- Sub-module `rampa_duty`: combinational next-shadow computation from (duty_actual, cuenta_max, PASO), instantiated only under `PWM_RAMPA_EN`.
- Counter, FSM and compare stay in `generador_pwm`.

## Test plan
- Reset asserted mid-period with duty 480 → next cycle `pwm_out`=0, `duty_actual`=0, `fin_periodo`=0; held while `reset`=1 even with `habilitar`=1.
- Macro off, `cuenta_max`=512, enable → exactly 512 high clocks followed by 512 low clocks per period; `fin_periodo` pulses every 1024 clocks.
- Edge duties: 0 → `pwm_out` never high; 992 → 992 high / 32 low; 1023 → 1023 high / 1 low.
- `cuenta_max` changed 256→768 at counter 100 → the current period still has 256 high clocks; the next period has 768.
- `habilitar` dropped at counter 50 with duty 800 → `pwm_out` low next cycle and the counter held at 0; re-enable → new period starts at counter 0 with the latest `cuenta_max`.
- Macro on, `PASO`=32, enable with `cuenta_max`=100 → `duty_actual` is 32, 64, 96, 100 over successive periods; then set to 0 → 68, 36, 4, 0.
